// File: rtl/imem_loader_pkg.sv
// Shared types and stream constants for the boot-time instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the checksum state.
package imem_loader_pkg;

  localparam int unsigned GROUP_BYTES = 4;  // header, data and checksum fields are all 4 bytes

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WR,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [31:0] word_addr(input logic [15:0] cnt);
    return {14'd0, cnt, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Shifts host bytes in MSB-first and flags the byte that completes a 4-byte group.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_rdy
);

  logic [1:0] idx;

  assign word_next = {word[23:0], byte_data};
  assign word_rdy  = en && (idx == 2'(GROUP_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (en) begin
      idx  <= idx + 2'd1;
      word <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian word stream into IM while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-2^32 checksum of the image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned IMEM_SIZE   = 1024,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        BYTE_VALID,
  input  logic [7:0]  BYTE_DATA,
  output logic        BYTE_READY,
  input  logic [31:0] CPU_PC,
  output logic [31:0] IM_ADDR,
  output logic        IM_WE,
  output logic [31:0] IM_W_INS,
  output logic        CPU_HOLD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] WORD_CNT
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
  logic [31:0] csum;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t      state, state_next;
  logic [31:0] n_words, timer, word, word_next;
  logic [15:0] cnt;
  logic        accept, start_ok, timeout, last_wr, word_rdy;

  assign start_ok = START && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign accept   = BYTE_VALID && BYTE_READY;
  // BYTE_READY is high exactly in the states where the inactivity timer runs
  assign timeout  = BYTE_READY && !accept && (timer == 32'(TIMEOUT_CYC - 1));
  assign last_wr  = ({16'd0, cnt + 16'd1} == n_words);

  imem_loader_byte_assembler u_asm (
    .clk       (CLK),
    .rst_n     (RST),
    .clr       (start_ok),
    .en        (accept),
    .byte_data (BYTE_DATA),
    .word      (word),
    .word_next (word_next),
    .word_rdy  (word_rdy)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start_ok) state_next = S_HDR;
      S_HDR: begin
        if (timeout) state_next = S_ERR;
        else if (word_rdy) begin
          if (word_next > IMEM_SIZE) state_next = S_ERR;
          else if (word_next == '0)  state_next = S_FIN;
          else                       state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (timeout)       state_next = S_ERR;
        else if (word_rdy) state_next = S_WR;
      end
      S_WR: state_next = last_wr ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (timeout)       state_next = S_ERR;
        else if (word_rdy) state_next = (word_next == csum) ? S_DONE : S_ERR;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    BYTE_READY = 1'b0;
    CPU_HOLD   = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ERR        = 1'b0;
    IM_WE      = 1'b0;
    case (state)
      S_HDR, S_DATA: begin
        BYTE_READY = 1'b1;
        CPU_HOLD   = 1'b1;
        BUSY       = 1'b1;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        BYTE_READY = 1'b1;
        CPU_HOLD   = 1'b1;
        BUSY       = 1'b1;
      end
`endif
      S_WR: begin
        CPU_HOLD = 1'b1;
        BUSY     = 1'b1;
        IM_WE    = 1'b1;
      end
      S_DONE: DONE = 1'b1;
      S_ERR: begin
        CPU_HOLD = 1'b1;
        ERR      = 1'b1;
      end
      default: ;
    endcase
    IM_ADDR  = CPU_HOLD ? word_addr(cnt) : CPU_PC;
    IM_W_INS = word;
    WORD_CNT = cnt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      n_words <= '0;
      timer   <= '0;
      cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else if (start_ok) begin
      n_words <= '0;
      timer   <= '0;
      cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      if (state == S_HDR && word_rdy) n_words <= word_next;
      if (accept)          timer <= '0;
      else if (BYTE_READY) timer <= timer + 32'd1;
      if (state == S_WR) begin
        cnt  <= cnt + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum + word;
`endif
      end
    end
  end

endmodule
